// File: rtl/qea_pkg.sv
// Shared definitions for the QEA host sequencer: FSM encoding, error codes
// and the initial-state amplitude constant.
package qea_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_CTX,
        S_INIT_ST,
        S_START,
        S_RUN,
        S_READ_REQ,
        S_READ_WAIT,
        S_READ_HOLD,
        S_FINISH
    } seq_state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_QBIT    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    // Amplitude 1.0 + 0.0i in Q2.30 re:im, written to basis state |0...0>.
    localparam logic [63:0] ONE_AMP = 64'h40000000_00000000;

endpackage

// File: rtl/qea_seq_counter.sv
// Loadable up-counter with a terminal-count flag against a runtime limit.
module qea_seq_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic [W-1:0] last,
    output logic [W-1:0] count,
    output logic         at_last
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

    // Terminal detect is an equality compare, so a full-range count never wraps.
    assign at_last = (count == last);

endmodule

// File: rtl/qea_host_sequencer.sv
// Host-side job sequencer: loads gate contexts, initialises the state RAM,
// starts the engine, times the run and streams the final state vector out.
import qea_pkg::*;

module qea_host_sequencer #(
    parameter int PE_NUM                  = 4,
    parameter int PE_NUM_WIDTH            = 2,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int STATE_DATA_WIDTH        = 64,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_CONTEXT_DATA_WIDTH = 64,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int CYC_WIDTH               = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_go,
    input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
    input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ins_num,
    input  logic [CYC_WIDTH-1:0]                 i_timeout,
    input  logic                                 i_ctxs_valid,
    output logic                                 o_ctxs_ready,
    input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctxs_data,
    output logic                                 o_ctx_en,
    output logic                                 o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
    output logic [PE_NUM-1:0]                    o_state_ena,
    output logic [PE_NUM-1:0]                    o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dout,
    output logic                                 o_start,
    input  logic                                 i_complete,
    output logic                                 o_rd_valid,
    input  logic                                 i_rd_ready,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_rd_data,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic [1:0]                           o_err,
    output logic [CYC_WIDTH-1:0]                 o_exec_cycles
);

    seq_state_t                          state;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]  ins_last_q;
    logic [STATE_ADDR_WIDTH-1:0]         st_last_q;
    logic [CYC_WIDTH-1:0]                timeout_q;

    logic                                qbit_bad;
    logic [MAX_QBIT_WIDTH-1:0]           depth_shift;
    logic [STATE_ADDR_WIDTH:0]           depth;
    logic                                accept;
    logic                                ctx_hs;

    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]  ctx_cnt;
    logic                                ctx_at_last;
    logic [STATE_ADDR_WIDTH-1:0]         st_cnt;
    logic                                st_at_last;
    logic                                st_load;
    logic                                st_inc;
    logic [CYC_WIDTH-1:0]                cyc_cnt;
    logic                                cyc_at_last;

    assign accept      = (state == S_IDLE) && i_go;
    assign qbit_bad    = (i_qbit_num < MAX_QBIT_WIDTH'(PE_NUM_WIDTH)) ||
                         (i_qbit_num > MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH + PE_NUM_WIDTH));
    assign depth_shift = i_qbit_num - MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
    // One extra bit so a full 2**STATE_ADDR_WIDTH depth still yields last = all-ones.
    assign depth       = (STATE_ADDR_WIDTH+1)'(1) << depth_shift;

    assign ctx_hs      = o_ctxs_ready && i_ctxs_valid;
    assign o_ctx_en    = ctx_hs;
    assign o_ctx_wea   = ctx_hs;
    assign o_ctx_addr  = ctx_hs ? ctx_cnt : '0;
    assign o_ctx_data  = ctx_hs ? i_ctxs_data : '0;

    assign st_load = accept || ((state == S_INIT_ST) && st_at_last);
    assign st_inc  = ((state == S_INIT_ST) && !st_at_last) ||
                     ((state == S_READ_HOLD) && i_rd_ready && !st_at_last);

    qea_seq_counter #(.W(GATE_CONTEXT_ADDR_WIDTH)) u_ctx_cnt (
        .clk(clk), .rst(rst), .load(accept), .load_val('0), .inc(ctx_hs),
        .last(ins_last_q), .count(ctx_cnt), .at_last(ctx_at_last)
    );

    qea_seq_counter #(.W(STATE_ADDR_WIDTH)) u_st_cnt (
        .clk(clk), .rst(rst), .load(st_load), .load_val('0), .inc(st_inc),
        .last(st_last_q), .count(st_cnt), .at_last(st_at_last)
    );

    qea_seq_counter #(.W(CYC_WIDTH)) u_cyc_cnt (
        .clk(clk), .rst(rst), .load(state == S_START), .load_val(CYC_WIDTH'(1)),
        .inc(state == S_RUN), .last(timeout_q), .count(cyc_cnt), .at_last(cyc_at_last)
    );

    always_comb begin
        o_state_ena   = '0;
        o_state_wea   = '0;
        o_state_addra = '0;
        o_state_dina  = '0;
        if (state == S_INIT_ST) begin
            o_state_ena   = '1;
            o_state_wea   = '1;
            o_state_addra = st_cnt;
            if (st_cnt == '0) begin
                o_state_dina[PE_NUM*STATE_DATA_WIDTH-1 -: STATE_DATA_WIDTH] = STATE_DATA_WIDTH'(ONE_AMP);
            end
        end else if (state == S_READ_REQ) begin
            o_state_ena   = '1;
            o_state_addra = st_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            ins_last_q    <= '0;
            st_last_q     <= '0;
            timeout_q     <= '0;
            o_ctxs_ready  <= 1'b0;
            o_start       <= 1'b0;
            o_rd_valid    <= 1'b0;
            o_rd_data     <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_err         <= ERR_NONE;
            o_exec_cycles <= '0;
        end else begin
            o_start <= 1'b0;
            o_done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_go) begin
                        o_busy     <= 1'b1;
                        ins_last_q <= i_ins_num - GATE_CONTEXT_ADDR_WIDTH'(1);
                        st_last_q  <= STATE_ADDR_WIDTH'(depth - (STATE_ADDR_WIDTH+1)'(1));
                        timeout_q  <= i_timeout;
                        if (qbit_bad) begin
                            o_err  <= ERR_QBIT;
                            o_done <= 1'b1;
                            state  <= S_FINISH;
                        end else begin
                            o_err <= ERR_NONE;
                            if (i_ins_num == '0) begin
                                state <= S_INIT_ST;
                            end else begin
                                o_ctxs_ready <= 1'b1;
                                state        <= S_LOAD_CTX;
                            end
                        end
                    end
                end
                S_LOAD_CTX: begin
                    if (ctx_hs && ctx_at_last) begin
                        o_ctxs_ready <= 1'b0;
                        state        <= S_INIT_ST;
                    end
                end
                S_INIT_ST: begin
                    if (st_at_last) begin
                        o_start <= 1'b1;
                        state   <= S_START;
                    end
                end
                S_START: state <= S_RUN;
                S_RUN: begin
                    // Completion is checked first so it wins over a coincident timeout.
                    if (i_complete) begin
                        o_exec_cycles <= cyc_cnt;
                        state         <= S_READ_REQ;
                    end else if ((timeout_q != '0) && cyc_at_last) begin
                        o_err  <= ERR_TIMEOUT;
                        o_done <= 1'b1;
                        state  <= S_FINISH;
                    end
                end
                S_READ_REQ: state <= S_READ_WAIT;
                S_READ_WAIT: begin
                    o_rd_data  <= i_state_dout;
                    o_rd_valid <= 1'b1;
                    state      <= S_READ_HOLD;
                end
                S_READ_HOLD: begin
                    if (i_rd_ready) begin
                        o_rd_valid <= 1'b0;
                        if (st_at_last) begin
                            o_done <= 1'b1;
                            state  <= S_FINISH;
                        end else begin
                            state <= S_READ_REQ;
                        end
                    end
                end
                S_FINISH: begin
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qea_host_sequencer.sv
// Directed scoreboard bench for qea_host_sequencer: jobs push expected RAM
// writes, start, readout words and done status; a negedge monitor pops and compares.
module tb_qea_host_sequencer;

    logic         clk;
    logic         rst;
    logic         i_go;
    logic [5:0]   i_qbit_num;
    logic [15:0]  i_ins_num;
    logic [31:0]  i_timeout;
    logic         i_ctxs_valid;
    logic         o_ctxs_ready;
    logic [63:0]  i_ctxs_data;
    logic         o_ctx_en;
    logic         o_ctx_wea;
    logic [15:0]  o_ctx_addr;
    logic [63:0]  o_ctx_data;
    logic [3:0]   o_state_ena;
    logic [3:0]   o_state_wea;
    logic [15:0]  o_state_addra;
    logic [255:0] o_state_dina;
    logic [255:0] i_state_dout;
    logic         o_start;
    logic         i_complete;
    logic         o_rd_valid;
    logic         i_rd_ready;
    logic [255:0] o_rd_data;
    logic         o_busy;
    logic         o_done;
    logic [1:0]   o_err;
    logic [31:0]  o_exec_cycles;

    int vectors = 0;
    int miscompares = 0;

    logic [79:0]  ctx_q[$];
    logic [271:0] st_q[$];
    logic [255:0] rd_q[$];
    logic [16:0]  start_q[$];
    logic [35:0]  done_q[$];

    logic         hold_prev = 1'b0;
    logic [255:0] prev_rd = '0;
    int           st_wr_cnt = 0;

    qea_host_sequencer dut (
        .clk(clk), .rst(rst), .i_go(i_go), .i_qbit_num(i_qbit_num),
        .i_ins_num(i_ins_num), .i_timeout(i_timeout),
        .i_ctxs_valid(i_ctxs_valid), .o_ctxs_ready(o_ctxs_ready), .i_ctxs_data(i_ctxs_data),
        .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea), .o_ctx_addr(o_ctx_addr), .o_ctx_data(o_ctx_data),
        .o_state_ena(o_state_ena), .o_state_wea(o_state_wea), .o_state_addra(o_state_addra),
        .o_state_dina(o_state_dina), .i_state_dout(i_state_dout),
        .o_start(o_start), .i_complete(i_complete),
        .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready), .o_rd_data(o_rd_data),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_exec_cycles(o_exec_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ctx_pat(input int i);
        return {16'hC7A5, 16'(i), 16'(i * 7 + 3), 16'hE00D ^ 16'(i)};
    endfunction

    function automatic logic [255:0] rd_pat(input logic [15:0] a);
        logic [255:0] w;
        for (int l = 0; l < 4; l++) begin
            w[l*64 +: 64] = {8'hA0 + 8'(l), 8'h00, a, 8'h5C, 8'(l), ~a};
        end
        return w;
    endfunction

    // Engine state-RAM read port, one cycle of latency.
    initial i_state_dout = '0;
    always @(posedge clk) begin
        if (o_state_ena != 4'd0 && o_state_wea == 4'd0) i_state_dout <= rd_pat(o_state_addra);
    end

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [319:0] act);
        vectors++;
        miscompares++;
        $display("FAIL %s: unexpected activity %h, none expected", name, act);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, 320'({o_ctxs_ready, o_ctx_en, o_ctx_wea, o_ctx_addr, o_state_ena,
                                   o_state_wea, o_state_addra, o_start, o_rd_valid, o_busy,
                                   o_done, o_err, o_exec_cycles}), 320'(0));
        check({tag, "_data"}, 320'({o_ctx_data, o_state_dina}), 320'(0));
        check({tag, "_rd_data"}, 320'(o_rd_data), 320'(0));
    endtask

    always @(negedge clk) begin : monitor
        logic [79:0]  ce;
        logic [271:0] se;
        logic [255:0] re;
        logic [16:0]  de;
        logic [35:0]  fe;
        if (rst) begin
            hold_prev = 1'b0;
            st_wr_cnt = 0;
        end else begin
            if (o_ctx_en || o_ctx_wea) begin
                if (ctx_q.size() == 0) unexpected("ctx_write", 320'({o_ctx_addr, o_ctx_data}));
                else begin
                    ce = ctx_q.pop_front();
                    check("ctx_write", 320'({o_ctx_en, o_ctx_wea, o_ctx_addr, o_ctx_data}), 320'({2'b11, ce}));
                end
            end
            if (o_state_ena != 4'd0 && o_state_wea != 4'd0) begin
                st_wr_cnt++;
                if (st_q.size() == 0) unexpected("state_write", 320'({o_state_addra, o_state_dina}));
                else begin
                    se = st_q.pop_front();
                    check("state_write", 320'({o_state_ena, o_state_wea, o_state_addra, o_state_dina}),
                          320'({8'hFF, se}));
                end
            end
            if (o_start) begin
                if (start_q.size() == 0) unexpected("start_pulse", 320'(st_wr_cnt));
                else begin
                    de = start_q.pop_front();
                    check("start_after_init", 320'(st_wr_cnt), 320'(de));
                end
                st_wr_cnt = 0;
            end
            if (hold_prev) check("rd_hold", 320'({o_rd_valid, o_rd_data}), 320'({1'b1, prev_rd}));
            hold_prev = o_rd_valid && !i_rd_ready;
            prev_rd   = o_rd_data;
            if (o_rd_valid && i_rd_ready) begin
                if (rd_q.size() == 0) unexpected("rd_data", 320'(o_rd_data));
                else begin
                    re = rd_q.pop_front();
                    check("rd_data", 320'(o_rd_data), 320'(re));
                end
            end
            if (o_done) begin
                st_wr_cnt = 0;
                if (done_q.size() == 0) unexpected("done_pulse", 320'({o_busy, o_err, o_exec_cycles}));
                else begin
                    fe = done_q.pop_front();
                    if (fe[35]) check("done_status", 320'({o_busy, o_err, o_exec_cycles}), 320'(fe[34:0]));
                    else        check("done_status", 320'({o_busy, o_err}), 320'(fe[34:32]));
                end
            end
        end
    end

    // abort_mode: 0 none, 1 reset at INIT write of address 100, 2 reset mid stalled READ_HOLD.
    task automatic run_job(input int qbit, input int ins, input int tmo, input int cmpl_dly,
                           input int stall_word, input int stall_len, input bit go_in_run,
                           input bit gaps, input int abort_mode, input logic [1:0] exp_err);
        int  d, ctx_idx, cyc, timer, go_timer, stall_left, rd_hs;
        bit  ok, hs, st, fin, aborted;
        ok = (exp_err != 2'd1);
        if (ok) begin
            d = 1 << (qbit - 2);
            for (int a = 0; a < d; a++) begin
                st_q.push_back({16'(a), (a == 0) ? {64'h40000000_00000000, 192'd0} : 256'd0});
                if (exp_err == 2'd0) rd_q.push_back(rd_pat(16'(a)));
            end
            start_q.push_back(17'(d));
        end
        if (exp_err == 2'd0) done_q.push_back({1'b1, 1'b1, 2'd0, 32'(cmpl_dly)});
        else                 done_q.push_back({1'b0, 1'b1, exp_err, 32'd0});

        @(posedge clk); #1;
        i_qbit_num = 6'(qbit);
        i_ins_num  = 16'(ins);
        i_timeout  = 32'(tmo);
        i_go       = 1'b1;
        ctx_idx    = 0;
        i_ctxs_data = ctx_pat(0);
        if (ok && ins > 0) begin
            ctx_q.push_back({16'd0, ctx_pat(0)});
            i_ctxs_valid = 1'b1;
        end else begin
            // A rejected or empty job must never take this word.
            i_ctxs_valid = !ok;
        end
        @(posedge clk); #1;
        i_go = 1'b0;

        fin = 0; aborted = 0; cyc = 0; timer = 0; go_timer = 0; rd_hs = 0;
        stall_left = stall_len;
        while (!fin && cyc < 20000) begin
            @(negedge clk);
            hs  = i_ctxs_valid && o_ctxs_ready;
            st  = o_start;
            fin = o_done;
            if (o_rd_valid && i_rd_ready) rd_hs++;
            if (o_rd_valid && !i_rd_ready && stall_left > 0) stall_left--;
            if (abort_mode == 1 && o_state_wea != 4'd0 && o_state_addra == 16'd100) aborted = 1;
            if (abort_mode == 2 && o_rd_valid && !i_rd_ready && stall_left == 3) aborted = 1;
            @(posedge clk); #1;
            cyc++;
            if (aborted) break;
            if (ok) begin
                if (hs) begin
                    ctx_idx++;
                    if (ctx_idx < ins) begin
                        i_ctxs_data = ctx_pat(ctx_idx);
                        ctx_q.push_back({16'(ctx_idx), ctx_pat(ctx_idx)});
                    end
                end
                i_ctxs_valid = (ctx_idx < ins) && (!gaps || $urandom_range(0, 2) != 0);
            end
            if (i_complete) i_complete = 1'b0;
            else if (st && cmpl_dly == 1) i_complete = 1'b1;
            else if (st && cmpl_dly > 1) timer = cmpl_dly - 1;
            else if (timer > 0) begin
                timer--;
                if (timer == 0) i_complete = 1'b1;
            end
            if (st && go_in_run) go_timer = 10;
            else if (go_timer > 0) begin
                go_timer--;
                if (go_timer == 0) begin
                    i_go = 1'b1;
                    i_qbit_num = 6'd1;
                end
            end else i_go = 1'b0;
            i_rd_ready = !(rd_hs == stall_word && stall_left > 0);
        end

        i_go = 1'b0; i_ctxs_valid = 1'b0; i_complete = 1'b0; i_rd_ready = 1'b1;
        if (aborted) begin
            rst = 1'b1;
            ctx_q.delete(); st_q.delete(); rd_q.delete(); start_q.delete(); done_q.delete();
            @(posedge clk);
            @(negedge clk);
            check_all_zero("abort_reset");
            @(posedge clk); #1;
            rst = 1'b0;
        end else begin
            if (!fin) unexpected("job_cycle_budget", 320'(cyc));
            @(negedge clk);
            check("idle_after_done", 320'({o_busy, o_done}), 320'(0));
            check("leftover_expectations", 320'({ctx_q.size(), st_q.size(), rd_q.size(),
                                                 start_q.size(), done_q.size()}), 320'(0));
        end
    endtask

    initial begin
        rst = 1'b1; i_go = 1'b0; i_qbit_num = '0; i_ins_num = '0; i_timeout = '0;
        i_ctxs_valid = 1'b0; i_ctxs_data = '0; i_complete = 1'b0; i_rd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");

        //       qbit ins  tmo cmpl stall len go_run gaps abort err
        run_job(12, 177,   0, 500,   3,  7, 0, 0, 0, 2'd0);
        run_job( 1,   5,   0,   0,  -1,  0, 0, 0, 0, 2'd1);
        run_job(19,   5,   0,   0,  -1,  0, 0, 0, 0, 2'd1);
        run_job( 2,   0,   0,   3,  -1,  0, 0, 0, 0, 2'd0);
        run_job( 4,   3, 100,   0,  -1,  0, 1, 0, 0, 2'd2);
        run_job(10,   8,   0,  50,  -1,  0, 0, 1, 1, 2'd0);
        run_job( 5,  20,   0,  37,   1,  2, 0, 1, 0, 2'd0);
        run_job( 6,   4,   0,  20,   5, 10, 0, 0, 2, 2'd0);
        run_job( 8,  40,  60,  60,   0,  2, 0, 1, 0, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
